// File: rtl/nic_interface.sv
// NIC with one-entry send and receive buffers between a processor port
// and a router port; the send side honours the router's polarity phase.
module nic_interface (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_so,
  input  logic        net_ro,
  output logic [63:0] net_do,
  input  logic        net_polarity,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [63:0] net_di
);

  logic [63:0] out_buf;
  logic [63:0] in_buf;
  logic        out_full;
  logic        in_full;
  logic        wr_out;
  logic        rd_in;
  logic        rd_en;

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_out = nicEn & nicWrEn & (addr == 2'b10);
  assign rd_in  = rd_en & (addr == 2'b00);

  assign net_so = out_full & net_ro
                & (out_buf[63] == net_polarity);
  assign net_do = out_buf;
  // hold off the router while reset is asserted
  assign net_ri = ~in_full & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (net_so) begin
      out_full <= 1'b0;
    end else if (wr_out && !out_full) begin
      out_buf  <= d_in;
      out_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (rd_in && in_full) begin
      in_full <= 1'b0;
    end else if (net_si && net_ri) begin
      in_buf  <= net_di;
      in_full <= 1'b1;
    end
  end

  always_comb begin
    d_out = '0;
    if (rd_en && !reset) begin
      unique case (addr)
        2'b00: d_out = in_buf;
        2'b01: d_out = {63'b0, in_full};
        2'b10: d_out = out_buf;
        2'b11: d_out = {63'b0, out_full};
      endcase
    end
  end

endmodule

// File: tb/tb_nic_interface.sv
// Directed bench for nic_interface: send, polarity stall, full drop,
// receive with held router send, and asynchronous reset.
module tb_nic_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [63:0] PKT_S = 64'hC010_0000_1111_1111;
  localparam logic [63:0] PKT_R = 64'h4010_0001_2222_2222;
  localparam logic [63:0] PKT_R2 = 64'h5555_0000_3333_3333;

  always #5 clk = ~clk;

  nic_interface dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn = 1'b0;
    nicWrEn = 1'b0;
    addr = 2'b00;
    d_in = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1;
    nicWrEn = 1'b1;
    addr = a;
    d_in = d;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1;
    nicWrEn = 1'b0;
    addr = a;
    d_in = '0;
  endtask

  initial begin
    reset = 1'b1;
    net_ro = 1'b0;
    net_polarity = 1'b0;
    net_si = 1'b0;
    net_di = '0;
    idle();
    #1;
    rd(2'b00);
    #1;
    check("rst_ri", 64'(net_ri), 64'd0);
    check("rst_so", 64'(net_so), 64'd0);
    check("rst_dout", d_out, 64'd0);
    check("rst_do", net_do, 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    idle();
    #1;
    check("post_ri", 64'(net_ri), 64'd1);
    check("post_so", 64'(net_so), 64'd0);
    rd(2'b11);
    #1;
    check("post_st11", d_out, 64'd0);

    // basic send
    net_ro = 1'b1;
    net_polarity = 1'b1;
    cyc();
    wr(2'b10, PKT_S);
    #1;
    check("wr_dout0", d_out, 64'd0);
    cyc();
    idle();
    #1;
    check("send_so", 64'(net_so), 64'd1);
    check("send_do", net_do, PKT_S);
    cyc();
    check("send_so_gone", 64'(net_so), 64'd0);
    rd(2'b11);
    #1;
    check("send_st11", d_out, 64'd0);

    // polarity stall
    net_polarity = 1'b0;
    cyc();
    wr(2'b10, PKT_S);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_so", 64'(net_so), 64'd0);
      cyc();
    end
    net_polarity = 1'b1;
    #1;
    check("unstall_so", 64'(net_so), 64'd1);
    cyc();
    rd(2'b11);
    #1;
    check("unstall_st11", d_out, 64'd0);

    // full drop
    net_ro = 1'b0;
    cyc();
    wr(2'b10, 64'hA);
    cyc();
    wr(2'b10, 64'hB);
    cyc();
    rd(2'b10);
    #1;
    check("drop_buf", d_out, 64'hA);
    rd(2'b11);
    #1;
    check("drop_st11", d_out, 64'd1);
    // write landing on the clearing edge is lost
    net_polarity = 1'b0;
    net_ro = 1'b1;
    wr(2'b10, 64'hC);
    cyc();
    net_ro = 1'b0;
    rd(2'b11);
    #1;
    check("clr_edge_st", d_out, 64'd0);
    rd(2'b10);
    #1;
    check("clr_edge_buf", d_out, 64'hA);
    // writes to other addresses are ignored
    wr(2'b11, 64'h1);
    cyc();
    wr(2'b00, 64'h77);
    cyc();
    wr(2'b01, 64'h1);
    cyc();
    rd(2'b11);
    #1;
    check("ign_st11", d_out, 64'd0);
    rd(2'b01);
    #1;
    check("ign_st01", d_out, 64'd0);
    rd(2'b00);
    #1;
    check("ign_buf00", d_out, 64'd0);

    // receive
    idle();
    net_si = 1'b1;
    net_di = PKT_R;
    #1;
    check("rx_ri_pre", 64'(net_ri), 64'd1);
    cyc();
    net_di = PKT_R2;
    #1;
    check("rx_ri_full", 64'(net_ri), 64'd0);
    cyc();
    rd(2'b01);
    #1;
    check("rx_st01", d_out, 64'd1);
    rd(2'b00);
    #1;
    check("rx_buf", d_out, PKT_R);
    cyc();
    idle();
    #1;
    check("rx_ri_clr", 64'(net_ri), 64'd1);
    cyc();
    net_si = 1'b0;
    #1;
    check("rx2_ri", 64'(net_ri), 64'd0);
    rd(2'b00);
    #1;
    check("rx2_buf", d_out, PKT_R2);
    cyc();
    #1;
    check("rx2_ri_clr", 64'(net_ri), 64'd1);
    cyc();
    check("stale_buf", d_out, PKT_R2);
    rd(2'b01);
    #1;
    check("stale_st01", d_out, 64'd0);

    // async reset with both buffers full
    idle();
    net_ro = 1'b0;
    net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0001);
    net_si = 1'b1;
    net_di = PKT_R;
    cyc();
    idle();
    net_si = 1'b0;
    net_ro = 1'b1;
    net_polarity = 1'b1;
    rd(2'b11);
    #1;
    check("ar_so_pre", 64'(net_so), 64'd1);
    check("ar_st_pre", d_out, 64'd1);
    reset = 1'b1;
    #1;
    check("ar_so", 64'(net_so), 64'd0);
    check("ar_dout", d_out, 64'd0);
    check("ar_ri", 64'(net_ri), 64'd0);
    check("ar_do", net_do, 64'd0);
    #1;
    reset = 1'b0;
    #1;
    check("ar_st11", d_out, 64'd0);
    rd(2'b01);
    #1;
    check("ar_st01", d_out, 64'd0);
    check("ar_ri_rel", 64'(net_ri), 64'd1);
    check("ar_so_rel", 64'(net_so), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
